// File: rtl/operand_fetch.sv
// Operand-fetch stage: 16x8 register file, pending-write scoreboard and a registered valid/ready operand bundle.
// Optional same-cycle writeback forwarding is enabled by defining OPFETCH_BYPASS_EN.
module operand_fetch #(
    parameter int W    = 8,
    parameter int NREG = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_opcode,
    input  logic [3:0]   in_ra,
    input  logic [W-1:0] in_b_val,
    input  logic         in_b_const,
    input  logic         in_wr,
    input  logic [3:0]   in_rd,
    input  logic         wb_en,
    input  logic [3:0]   wb_addr,
    input  logic [W-1:0] wb_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_opcode,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic         out_b_const,
    output logic         out_wr,
    output logic [3:0]   out_rd
);

    logic [NREG-1:0][W-1:0] r_regs;
    logic [NREG-1:0]        r_pend;

    logic                   r_out_valid;
    logic [3:0]             r_out_opcode;
    logic [W-1:0]           r_out_a;
    logic [W-1:0]           r_out_b;
    logic                   r_out_b_const;
    logic                   r_out_wr;
    logic [3:0]             r_out_rd;

    logic [3:0]             w_b_idx;
    logic [NREG-1:0]        w_clr;
    logic [NREG-1:0]        w_set;
    logic [NREG-1:0]        w_pend_vis;
    logic [W-1:0]           w_rd_a;
    logic [W-1:0]           w_rd_b;
    logic [W-1:0]           w_b;
    logic                   w_hazard;
    logic                   w_accept;

    assign w_b_idx = in_b_val[3:0];

    always_comb begin
        w_clr = '0;
        if (wb_en)
            w_clr[wb_addr] = 1'b1;
    end

    always_comb begin
        w_set = '0;
        if (w_accept && in_wr)
            w_set[in_rd] = 1'b1;
    end

`ifdef OPFETCH_BYPASS_EN
    // A register being written back this cycle is already resolved: forward its data.
    assign w_pend_vis = r_pend & ~w_clr;

    always_comb begin
        w_rd_a = r_regs[in_ra];
        w_rd_b = r_regs[w_b_idx];
        if (wb_en && (wb_addr == in_ra))
            w_rd_a = wb_data;
        if (wb_en && (wb_addr == w_b_idx))
            w_rd_b = wb_data;
    end
`else
    assign w_pend_vis = r_pend;

    always_comb begin
        w_rd_a = r_regs[in_ra];
        w_rd_b = r_regs[w_b_idx];
    end
`endif

    assign w_b = in_b_const ? in_b_val : w_rd_b;

    // Constant B operands never look at the scoreboard.
    assign w_hazard = in_valid &&
                      (w_pend_vis[in_ra] ||
                       (!in_b_const && w_pend_vis[w_b_idx]) ||
                       (in_wr && w_pend_vis[in_rd]));

    assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_regs <= '0;
        end else if (wb_en) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Set is applied after clear so an issue and a writeback to the same index leave it pending.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_pend <= '0;
        else
            r_pend <= (r_pend & ~w_clr) | w_set;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_out_valid   <= 1'b0;
            r_out_opcode  <= '0;
            r_out_a       <= '0;
            r_out_b       <= '0;
            r_out_b_const <= 1'b0;
            r_out_wr      <= 1'b0;
            r_out_rd      <= '0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_opcode  <= in_opcode;
            r_out_a       <= w_rd_a;
            r_out_b       <= w_b;
            r_out_b_const <= in_b_const;
            r_out_wr      <= in_wr;
            r_out_rd      <= in_rd;
        end else if (r_out_valid && out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_opcode  = r_out_opcode;
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign out_b_const = r_out_b_const;
    assign out_wr      = r_out_wr;
    assign out_rd      = r_out_rd;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage sitting directly downstream of the constant LUT in the decode path. Each cycle it accepts one decoded instruction whose B operand is either an 8-bit constant or a register pointer, as given by the LUT's const flag. It reads the 16×8 register file it owns, resolves read-after-write hazards with a pending-write scoreboard, and presents both operand values to the ALU stage through a registered valid/ready output. Writeback from the end of the pipeline returns into this block.

## Interface
Parameters:
- `W`, 8 — datapath width.
- `NREG`, 16 — number of registers; register index is 4 bits.

Ports:
- `Clk` in 1 — clock; all state updates on the rising edge.
- `Reset` in 1 — asynchronous, active-high reset.
- `in_valid` in 1 — decoded instruction present.
- `in_ready` out 1 — stage accepts the instruction this cycle.
- `in_opcode` in 4 — passed through unchanged.
- `in_ra` in 4 — A operand register index.
- `in_b_val` in W — LUT constant output; when `in_b_const`=0, bits [3:0] are the B register index.
- `in_b_const` in 1 — LUT const flag.
- `in_wr` in 1 — instruction writes `in_rd`.
- `in_rd` in 4 — destination register index.
- `wb_en` in 1 — writeback strobe.
- `wb_addr` in 4 — writeback register index.
- `wb_data` in W — writeback value.
- `out_valid` out 1 — operand bundle valid.
- `out_ready` in 1 — ALU stage accepts the bundle.
- `out_opcode` out 4, `out_a` out W, `out_b` out W, `out_b_const` out 1, `out_wr` out 1, `out_rd` out 4 — registered operand bundle.

## Operation
- Register file: NREG×W flops, all cleared on `Reset`. Written when `wb_en`=1.
- Reads are combinational. B source is `in_b_val` when `in_b_const`=1; otherwise it is `regs[in_b_val[3:0]]`.
- Scoreboard: `pend[NREG]`, cleared on reset.
  - Set `pend[in_rd]` on accept with `in_wr`=1.
  - Clear `pend[wb_addr]` when `wb_en`=1.
  - If set and clear hit the same index in the same cycle, set wins.
- Hazard when `in_valid`=1 and any of the following holds:
  - `pend[in_ra]`;
  - `in_b_const`=0 and `pend[in_b_val[3:0]]`;
  - `in_wr`=1 and `pend[in_rd]` (WAW).
  - A pending bit being cleared by writeback this cycle does not count as a hazard, but only when bypass is enabled (see Configuration).
- `in_ready` = (!`out_valid` || `out_ready`) && !hazard. `in_ready` depends combinationally on the input fields; this is permitted.
- Accept = `in_valid` && `in_ready`. On accept, the output bundle registers load.
- If `out_valid` && `out_ready` with no accept, `out_valid` drops to 0 and the bundle is held unchanged.
- Constant operands never consult the scoreboard.

## Timing
- Reset: `out_valid`=0; all `out_*` fields = 0; regs = 0; pend = 0.
- Latency: 1 cycle from accept to `out_valid`. Full throughput of 1 instruction per cycle when there are no hazards and `out_ready`=1.
- Output hold: while `out_valid`=1 and `out_ready`=0, all `out_*` are stable and `in_ready`=0.
- Writeback lands in the register file at the edge; reads in the following cycle see the new value.
- Reset asserted mid-operation discards the held bundle and all pending bits immediately (asynchronously). After release, the first accept is possible in the first cycle.

## Configuration
- `OPFETCH_BYPASS_EN` defined:
  - A read whose index equals `wb_addr` while `wb_en`=1 returns `wb_data` in the same cycle.
  - The matching pending bit is treated as already clear for hazard detection.
  - A RAW stall therefore ends in the writeback cycle.
- Not defined:
  - No forwarding; a pending bit blocks until after the clearing edge.
  - The stall ends in the cycle after writeback, and the value is read from the register file.

## Test plan
- Reset, then `wb_en` to r3 with 0x5A; next cycle issue `in_ra`=3 with `in_b_const`=1, `in_b_val`=0x7F → one cycle later `out_valid`=1, `out_a`=0x5A, `out_b`=0x7F.
- Issue with `in_wr`=1, `in_rd`=2, then issue `in_ra`=2 → `in_ready`=0 until `wb_en`/`wb_addr`=2/`wb_data`=0x11. With bypass: accepted in the wb cycle, `out_a`=0x11. Without bypass: accepted one cycle later.
- B as register: `in_b_const`=0, `in_b_val`=0x05, r5=0x80 → `out_b`=0x80. Same case with r5 pending → stall.
- `out_ready`=0 for 3 cycles with a bundle held → `out_*` stable, `in_ready`=0; `out_ready`=1 → the new instruction is accepted in the same cycle.
- Same-cycle accept with `in_rd`=4, `in_wr`=1 and `wb_en` to r4 → `pend[4]`=1 afterwards.
- Assert `Reset` while `out_valid`=1 and `pend`≠0 → `out_valid`=0 and pend=0 immediately, with no clock edge needed.
